// File: rtl/instr_sequencer.sv
// Multicycle fetch/issue controller: fetches 16-bit instructions from a synchronous
// single-port memory and sequences ALU, LOAD, STORE, controller-input, branch and HALT.
//
// Handshake: ctrl_valid/ctrl_ack is a valid/consume pair. In CTL_WAIT, the controller
// waits for ctrl_valid=1. In that same cycle it pulses ctrl_ack for one cycle while
// ctrl_data is written back. ctrl_valid may already be high on entry to CTL_WAIT.
module instr_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mem_rdata,
  input  logic [15:0] reg_a,
  input  logic [15:0] reg_b,
  input  logic [15:0] flags,
  input  logic [15:0] ctrl_data,
  input  logic        ctrl_valid,
  output logic        ctrl_ack,
  output logic [15:0] instr,
  output logic        ren,
  output logic [1:0]  load_sel,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic [15:0] pc,
  output logic        halted,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_FWAIT    = 3'd1,
    S_EXEC     = 3'd2,
    S_LD_ADDR  = 3'd3,
    S_LD_WB    = 3'd4,
    S_ST       = 3'd5,
    S_CTL_WAIT = 3'd6,
    S_HALT     = 3'd7
  } state_e;

  localparam logic [7:0] OP_ALU_LAST = 8'h16;
  localparam logic [7:0] OP_CMP_LAST = 8'h0C;
  localparam logic [7:0] OP_LOAD     = 8'h99;
  localparam logic [7:0] OP_STORE    = 8'hDA;
  localparam logic [7:0] OP_CTLST    = 8'h80;
  localparam logic [7:0] OP_BEQ      = 8'hC0;
  localparam logic [7:0] OP_BNE      = 8'hC1;
  localparam logic [7:0] OP_BRA      = 8'hC2;
  localparam logic [7:0] OP_HALT     = 8'hFF;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        flag_z_q, flag_z_d;

  logic [7:0]  opcode;
  logic [15:0] pc_inc;
  logic [15:0] br_target;
  logic        ren_c, we_c, ack_c;
  logic [1:0]  ls_c;
  logic [15:0] addr_c;

  // The controller ignores ctrl_data and every flag except Z; the datapath consumes them.
  logic unused_inputs;
  assign unused_inputs = ^{ctrl_data, flags[15:5], flags[3:0]};

  assign opcode    = ir_q[15:8];
  assign pc_inc    = pc_q + 16'd1;
  assign br_target = pc_inc + {{8{ir_q[7]}}, ir_q[7:0]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= 16'h0017;
      flag_z_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      flag_z_q <= flag_z_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    flag_z_d = flag_z_q;
    ren_c    = 1'b0;
    we_c     = 1'b0;
    ack_c    = 1'b0;
    ls_c     = 2'b00;
    addr_c   = pc_q;
    unique case (state_q)
      S_FETCH: state_d = S_FWAIT;
      S_FWAIT: begin
        ir_d    = mem_rdata;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        if (opcode <= OP_ALU_LAST) begin
          // Compares only update Z; they have no register result.
          ren_c = !(opcode inside {[8'h0A:8'h0C]});
          if (opcode <= OP_CMP_LAST) flag_z_d = flags[4];
        end else begin
          case (opcode)
            OP_LOAD: begin
              state_d = S_LD_ADDR;
              pc_d    = pc_q;
            end
            OP_STORE: begin
              state_d = S_ST;
              pc_d    = pc_q;
            end
            OP_CTLST: begin
              state_d = S_CTL_WAIT;
              pc_d    = pc_q;
            end
            OP_BEQ: if (flag_z_q) pc_d = br_target;
            OP_BNE: if (!flag_z_q) pc_d = br_target;
            OP_BRA: pc_d = br_target;
            OP_HALT: begin
              state_d = S_HALT;
              pc_d    = pc_q;
            end
            default: ;
          endcase
        end
      end
      S_LD_ADDR: begin
        addr_c  = reg_a;
        state_d = S_LD_WB;
      end
      S_LD_WB: begin
        ls_c    = 2'b01;
        ren_c   = 1'b1;
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      S_ST: begin
        addr_c  = reg_b;
        we_c    = 1'b1;
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      S_CTL_WAIT: begin
        if (ctrl_valid) begin
          ls_c    = 2'b10;
          ren_c   = 1'b1;
          ack_c   = 1'b1;
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      S_HALT: ;
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are gated by reset so a reset edge never commits a write or an ack.
  assign ren       = ren_c & reset;
  assign mem_we    = we_c & reset;
  assign ctrl_ack  = ack_c & reset;
  assign load_sel  = reset ? ls_c : 2'b00;
  assign mem_addr  = addr_c;
  assign mem_wdata = reg_a;
  assign instr     = ir_q;
  assign pc        = pc_q;
  assign halted    = (state_q == S_HALT);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a behavioural memory and register-file datapath.
module tb_instr_sequencer;

  localparam logic [2:0] ST_FETCH = 3'd0, ST_FWAIT = 3'd1, ST_EXEC = 3'd2, ST_LD_ADDR = 3'd3,
                         ST_LD_WB = 3'd4, ST_ST = 3'd5, ST_CTL = 3'd6, ST_HALT = 3'd7;

  logic        clk, reset;
  logic [15:0] mem_rdata, reg_a, reg_b, flags, ctrl_data;
  logic        ctrl_valid, ctrl_ack, ren, mem_we, halted;
  logic [15:0] instr, mem_addr, mem_wdata, pc;
  logic [1:0]  load_sel;
  logic [2:0]  dbg_state;

  logic [15:0] mem [0:65535];
  logic [15:0] rf [16];
  int          n_cmp, n_fail;

  instr_sequencer #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .reg_a(reg_a), .reg_b(reg_b),
    .flags(flags), .ctrl_data(ctrl_data), .ctrl_valid(ctrl_valid), .ctrl_ack(ctrl_ack),
    .instr(instr), .ren(ren), .load_sel(load_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .pc(pc), .halted(halted), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Datapath read ports and Z flag (CMP: equal operands; others: a+b == 0)
  always_comb begin
    reg_a = rf[instr[7:4]];
    reg_b = rf[instr[3:0]];
    flags = 16'h0000;
    if (instr[15:8] inside {[8'h0A:8'h0C]}) flags[4] = (reg_a == reg_b);
    else flags[4] = ((reg_a + reg_b) == 16'h0000);
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  // One clock: sample DUT strobes at the negedge, commit memory/regfile just after posedge.
  task automatic tick();
    logic        we, rn;
    logic [15:0] a, wd, rd, ins, cd, ra, rb;
    logic [1:0]  ls;
    we = mem_we; rn = ren; a = mem_addr; wd = mem_wdata; rd = mem_rdata;
    ins = instr; cd = ctrl_data; ra = reg_a; rb = reg_b; ls = load_sel;
    @(posedge clk);
    #1;
    mem_rdata = mem[a];
    if (we) mem[a] = wd;
    if (rn) begin
      case (ls)
        2'b00:   rf[ins[7:4]] = ra + rb;
        2'b01:   rf[ins[3:0]] = rd;
        2'b10:   rf[ins[3:0]] = cd;
        default: ;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    ticks(2);
    reset = 1'b1;
  endtask

  int acks, writes_seen;

  initial begin
    n_cmp = 0; n_fail = 0;
    reset = 1'b0; ctrl_valid = 1'b0; ctrl_data = 16'h0000; mem_rdata = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h1700;
    for (int i = 0; i < 16; i++) rf[i] = 16'h0000;
    @(negedge clk);

    // Reset values and ADD r1,r2
    mem[0] = 16'h0012; rf[1] = 16'd3; rf[2] = 16'd4;
    reset = 1'b0;
    ticks(2);
    check("rst_state", dbg_state, ST_FETCH);
    check("rst_pc", pc, 16'h0000);
    check("rst_ir", instr, 16'h0017);
    check("rst_addr", mem_addr, 16'h0000);
    check("rst_strobes", {ren, mem_we, ctrl_ack, halted, load_sel}, 16'h0000);
    reset = 1'b1;
    check("add_c1_ren", ren, 1'b0);
    tick();
    check("add_c2_ren", ren, 1'b0);
    tick();
    check("add_c3_ir", instr, 16'h0012);
    check("add_c3_ren", ren, 1'b1);
    check("add_c3_ls", load_sel, 2'b00);
    tick();
    check("add_c4_state", dbg_state, ST_FETCH);
    check("add_c4_ren", ren, 1'b0);
    check("add_c4_pc", pc, 16'h0001);
    check("add_r1", rf[1], 16'd7);

    // LOAD r3 <- mem[r2]: five states from FETCH back to FETCH
    mem[0] = 16'h9923; rf[2] = 16'h0040; rf[3] = 16'h0000; mem[16'h0040] = 16'hBEEF;
    do_reset();
    ticks(3);
    check("ld_state", dbg_state, ST_LD_ADDR);
    check("ld_addr", mem_addr, 16'h0040);
    check("ld_addr_ren", ren, 1'b0);
    tick();
    check("ld_wb_state", dbg_state, ST_LD_WB);
    check("ld_wb_ren", ren, 1'b1);
    check("ld_wb_ls", load_sel, 2'b01);
    tick();
    check("ld_done_state", dbg_state, ST_FETCH);
    check("ld_pc", pc, 16'h0001);
    check("ld_r3", rf[3], 16'hBEEF);

    // STORE mem[r5] <- r4, then LOAD r6 <- mem[r5]
    mem[0] = 16'hDA45; mem[1] = 16'h9956; rf[4] = 16'h1234; rf[5] = 16'h0080; rf[6] = 16'h0000;
    do_reset();
    ticks(2);
    check("st_exec_we", mem_we, 1'b0);
    tick();
    check("st_state", dbg_state, ST_ST);
    check("st_we", mem_we, 1'b1);
    check("st_addr", mem_addr, 16'h0080);
    check("st_wdata", mem_wdata, 16'h1234);
    tick();
    check("st_after_we", mem_we, 1'b0);
    check("st_pc", pc, 16'h0001);
    check("st_mem", mem[16'h0080], 16'h1234);
    ticks(5);
    check("st_ld_pc", pc, 16'h0002);
    check("st_ld_r6", rf[6], 16'h1234);

    // CMP r1,r1 sets Z; BEQ -2 at pc=1 returns to 0
    mem[0] = 16'h0B11; mem[1] = 16'hC0FE; rf[1] = 16'h0005;
    do_reset();
    ticks(2);
    check("cmp_ren", ren, 1'b0);
    tick();
    check("cmp_pc", pc, 16'h0001);
    ticks(3);
    check("beq_pc", pc, 16'h0000);
    check("beq_addr", mem_addr, 16'h0000);

    // BNE with Z set falls through
    mem[1] = 16'hC1FE;
    do_reset();
    ticks(6);
    check("bne_pc", pc, 16'h0002);

    // BRA -2 from 0 wraps to 0xFFFF, BRA +1 there wraps to 1, then HALT
    mem[0] = 16'hC2FE; mem[16'hFFFF] = 16'hC201; mem[1] = 16'hFF00;
    do_reset();
    ticks(3);
    check("bra_pc_ffff", pc, 16'hFFFF);
    check("bra_addr_ffff", mem_addr, 16'hFFFF);
    ticks(3);
    check("bra_pc_wrap", pc, 16'h0001);
    ticks(3);
    check("halt_state", dbg_state, ST_HALT);
    check("halt_flag", halted, 1'b1);
    writes_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (ren || mem_we || ctrl_ack) writes_seen++;
      tick();
    end
    check("halt_pc", pc, 16'h0001);
    check("halt_still", halted, 1'b1);
    check("halt_writes", 16'(writes_seen), 16'd0);

    // CTLST r6 with ctrl_valid low for five wait cycles
    mem[0] = 16'h8006; rf[6] = 16'h0000; ctrl_data = 16'h00AA;
    do_reset();
    check("rst_from_halt", halted, 1'b0);
    ticks(3);
    check("ctl_state", dbg_state, ST_CTL);
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      if (ctrl_ack || ren) acks++;
      if (i < 4) tick();
    end
    check("ctl_wait_noack", 16'(acks), 16'd0);
    check("ctl_wait_pc", pc, 16'h0000);
    ctrl_valid = 1'b1;
    #1;
    check("ctl_ack", ctrl_ack, 1'b1);
    check("ctl_ren", ren, 1'b1);
    check("ctl_ls", load_sel, 2'b10);
    tick();
    ctrl_valid = 1'b0;
    check("ctl_ack_off", ctrl_ack, 1'b0);
    check("ctl_pc", pc, 16'h0001);
    check("ctl_r6", rf[6], 16'h00AA);

    // Reset arriving during ST suppresses the write
    mem[0] = 16'hDA45; rf[4] = 16'h5555; rf[5] = 16'h0090; mem[16'h0090] = 16'h0000;
    do_reset();
    ticks(3);
    check("rst_st_state", dbg_state, ST_ST);
    reset = 1'b0;
    #1;
    check("rst_st_we", mem_we, 1'b0);
    tick();
    reset = 1'b1;
    check("rst_st_mem", mem[16'h0090], 16'h0000);
    check("rst_st_fetch", dbg_state, ST_FETCH);
    check("rst_st_pc", pc, 16'h0000);
    check("rst_st_ir", instr, 16'h0017);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
